// File: rtl/ysyx_220053_trap_ctrl_pkg.sv
// Shared constants for the trap controller: FSM state encoding, the CSR
// addresses the trap path touches, and the cause codes reported on entry.
package ysyx_220053_trap_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SAVE = 2'd1;
  localparam logic [1:0] ST_JUMP = 2'd2;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [63:0] TRAP_CAUSE_ECALL = 64'hb;
  localparam logic [63:0] TRAP_CAUSE_TIMER = 64'h8000_0000_0000_0007;

endpackage

// File: rtl/ysyx_220053_trap_ctrl.sv
// Trap controller between execute and the CSR file. Takes ecall/mret
// requests, pulses the CSR trap-entry input for one cycle on ecall, and
// issues a PC redirect with flush to fetch over a valid/ready handshake.
// Optional feature macro: TRAP_TIMER_IRQ_EN (timer interrupt as trap source).
module ysyx_220053_trap_ctrl
  import ysyx_220053_trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_ecall,
  input  logic        req_mret,
  input  logic [63:0] req_pc,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] mepc_i,
  output logic        csr_ecall,
  output logic [63:0] csr_epc,
  output logic [63:0] cause,
  output logic        flush,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [63:0] redir_pc,
  output logic [31:0] trap_cnt,
  input  logic        timer_irq,
  input  logic        irq_en
);

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic [63:0] cause_q, cause_d;
  logic [31:0] cnt_q, cnt_d;
  logic        idle;
  logic        accept;
  logic        irq_take;

  assign idle = (state_q == ST_IDLE);

`ifdef TRAP_TIMER_IRQ_EN
  logic        irq_q, irq_d;
  logic [63:0] last_pc_q, last_pc_d;
  logic        unused_mtvec;
  assign unused_mtvec = ^mtvec_i[1:0];
  // A pending enabled timer interrupt blocks request acceptance while idle.
  assign irq_take = idle && timer_irq && irq_en;
`else
  logic        unused_in;
  assign unused_in = ^{timer_irq, irq_en, mtvec_i[1:0]};
  assign irq_take  = 1'b0;
`endif

  assign req_ready   = idle && !irq_take;
  assign accept      = req_valid && req_ready;
  assign csr_ecall   = (state_q == ST_SAVE);
  assign csr_epc     = pc_q;
  assign cause       = cause_q;
  assign flush       = !idle;
  assign redir_valid = (state_q == ST_JUMP);
  assign redir_pc    = tgt_q;
  assign trap_cnt    = cnt_q;

  // Next-state, latched PC/target, cause and counter updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
`ifdef TRAP_TIMER_IRQ_EN
    irq_d     = irq_q;
    last_pc_d = last_pc_q;
    if (accept) last_pc_d = req_pc;
`endif
    case (state_q)
      ST_IDLE: begin
        if (irq_take) begin
`ifdef TRAP_TIMER_IRQ_EN
          pc_d    = req_valid ? req_pc : (last_pc_q + 64'd4);
          irq_d   = 1'b1;
          state_d = ST_SAVE;
`endif
        end else if (accept) begin
          // ecall wins when both bits are set; neither bit just consumes.
          if (req_ecall) begin
            pc_d    = req_pc;
            state_d = ST_SAVE;
`ifdef TRAP_TIMER_IRQ_EN
            irq_d   = 1'b0;
`endif
          end else if (req_mret) begin
            tgt_d   = mepc_i;
            state_d = ST_JUMP;
          end
        end
      end
      ST_SAVE: begin
        // Direct mode only: the mtvec mode bits are dropped.
        tgt_d   = {mtvec_i[63:2], 2'b00};
        cause_d = TRAP_CAUSE_ECALL;
`ifdef TRAP_TIMER_IRQ_EN
        if (irq_q) cause_d = TRAP_CAUSE_TIMER;
`endif
        cnt_d   = cnt_q + 32'd1;
        state_d = ST_JUMP;
      end
      ST_JUMP: begin
        if (redir_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any trap in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= 64'd0;
      tgt_q   <= 64'd0;
      cause_q <= 64'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TRAP_TIMER_IRQ_EN
  // Interrupt-entry flag and last accepted PC for the interrupt epc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q     <= 1'b0;
      last_pc_q <= 64'd0;
    end else begin
      irq_q     <= irq_d;
      last_pc_q <= last_pc_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_220053_trap_ctrl.sv
// Directed bench for the trap controller: reset, ecall, mret, backpressure,
// request-bit corner cases, asynchronous reset mid-redirect, timer interrupt.
module tb_ysyx_220053_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_ecall, req_mret;
  logic [63:0] req_pc, mtvec_i, mepc_i;
  logic        csr_ecall;
  logic [63:0] csr_epc, cause;
  logic        flush, redir_valid, redir_ready;
  logic [63:0] redir_pc;
  logic [31:0] trap_cnt;
  logic        timer_irq, irq_en;

  int n_chk = 0;
  int n_err = 0;

  ysyx_220053_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ecall(req_ecall), .req_mret(req_mret), .req_pc(req_pc),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .csr_ecall(csr_ecall), .csr_epc(csr_epc), .cause(cause),
    .flush(flush), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .trap_cnt(trap_cnt),
    .timer_irq(timer_irq), .irq_en(irq_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_ecall = 1'b0;
    req_mret  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    req_pc = '0; mtvec_i = '0; mepc_i = '0;
    redir_ready = 1'b1; timer_irq = 1'b0; irq_en = 1'b0;
    step();
    step();
    chk("rst_flush", flush, 0);
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_csr_ecall", csr_ecall, 0);
    chk("rst_trap_cnt", trap_cnt, 0);
    chk("rst_cause", cause, 0);
    chk("rst_csr_epc", csr_epc, 0);
    chk("rst_redir_pc", redir_pc, 0);
    rst = 1'b0;
    step();
    chk("rst_req_ready", req_ready, 1);

    // Ecall round trip
    req_valid = 1'b1; req_ecall = 1'b1;
    req_pc = 64'h8000_0010; mtvec_i = 64'h8000_1003;
    step();
    idle_inputs();
    chk("ec_save_pulse", csr_ecall, 1);
    chk("ec_save_epc", csr_epc, 64'h8000_0010);
    chk("ec_save_flush", flush, 1);
    chk("ec_save_ready", req_ready, 0);
    chk("ec_save_rv", redir_valid, 0);
    step();
    chk("ec_jump_pulse", csr_ecall, 0);
    chk("ec_jump_rv", redir_valid, 1);
    chk("ec_jump_pc", redir_pc, 64'h8000_1000);
    chk("ec_cause", cause, 64'hb);
    chk("ec_cnt", trap_cnt, 1);
    step();
    chk("ec_idle_ready", req_ready, 1);
    chk("ec_idle_flush", flush, 0);

    // Mret: redirect one cycle after accept, no CSR pulse
    mepc_i = 64'h8000_0014;
    req_valid = 1'b1; req_mret = 1'b1;
    step();
    idle_inputs();
    chk("mret_rv", redir_valid, 1);
    chk("mret_pc", redir_pc, 64'h8000_0014);
    chk("mret_pulse", csr_ecall, 0);
    chk("mret_cnt", trap_cnt, 1);
    step();
    chk("mret_idle", req_ready, 1);

    // Backpressure in JUMP
    redir_ready = 1'b0;
    req_valid = 1'b1; req_ecall = 1'b1;
    req_pc = 64'h8000_0020; mtvec_i = 64'h8000_2001;
    step();
    idle_inputs();
    chk("bp_save", csr_ecall, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_pc", redir_pc, 64'h8000_2000);
      chk("bp_flush", flush, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_rv", redir_valid, 1);
      chk("bp_pulse", csr_ecall, 0);
      step();
    end
    chk("bp_cnt", trap_cnt, 2);
    redir_ready = 1'b1;
    step();
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_rv", redir_valid, 0);

    // Request with neither bit set is consumed without effect
    req_valid = 1'b1;
    step();
    idle_inputs();
    chk("none_flush", flush, 0);
    chk("none_rv", redir_valid, 0);
    chk("none_ready", req_ready, 1);
    chk("none_cnt", trap_cnt, 2);

`ifndef TRAP_TIMER_IRQ_EN
    // Timer interrupt is ignored in the default build
    timer_irq = 1'b1; irq_en = 1'b1;
    chk("irq_ign_ready", req_ready, 1);
    step();
    chk("irq_ign_flush", flush, 0);
    timer_irq = 1'b0; irq_en = 1'b0;
`endif

    // Both bits set: ecall path, then async reset while stalled in JUMP
    redir_ready = 1'b0;
    req_valid = 1'b1; req_ecall = 1'b1; req_mret = 1'b1;
    req_pc = 64'h8000_0030; mtvec_i = 64'h8000_3002; mepc_i = 64'h8000_0014;
    step();
    idle_inputs();
    chk("both_pulse", csr_ecall, 1);
    chk("both_epc", csr_epc, 64'h8000_0030);
    step();
    chk("both_pc", redir_pc, 64'h8000_3000);
    chk("both_cnt", trap_cnt, 3);
    chk("both_rv", redir_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_rv", redir_valid, 0);
    chk("arst_flush", flush, 0);
    chk("arst_cnt", trap_cnt, 0);
    chk("arst_cause", cause, 0);
    rst = 1'b0;
    redir_ready = 1'b1;
    step();
    chk("arst_ready", req_ready, 1);
    chk("arst_pulse", csr_ecall, 0);
    chk("arst_rv2", redir_valid, 0);

`ifdef TRAP_TIMER_IRQ_EN
    // Interrupt beats a coincident mret request
    timer_irq = 1'b1; irq_en = 1'b1;
    req_valid = 1'b1; req_mret = 1'b1;
    req_pc = 64'h8000_0040; mepc_i = 64'h8000_0050; mtvec_i = 64'h8000_4000;
    #1;
    chk("irq_ready", req_ready, 0);
    step();
    idle_inputs();
    timer_irq = 1'b0; irq_en = 1'b0;
    chk("irq_pulse", csr_ecall, 1);
    chk("irq_epc", csr_epc, 64'h8000_0040);
    step();
    chk("irq_cause", cause, 64'h8000_0000_0000_0007);
    chk("irq_pc", redir_pc, 64'h8000_4000);
    chk("irq_cnt", trap_cnt, 1);
    step();
    chk("irq_idle", req_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
